muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Parametrised iterative multiply/divide unit with its own HI/LO result registers. It sits beside the ALU in the CPU datapath and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. One operation runs at a time under a start/busy/done handshake, at one bit per cycle. The CPU reads HI/LO directly for MFHI/MFLO and uses `busy` to stall the PC.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: request; sampled on rising edge only while idle.
- `op` in 3: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `cancel` in 1: synchronous abort of an in-flight mul/div (exception flush).
- `a` in WIDTH: rs operand (multiplicand/dividend, MTHI/MTLO data).
- `b` in WIDTH: rt operand (multiplier/divisor).
- `busy` out 1: high while a mul/div is in flight.
- `done` out 1: one-cycle pulse when HI/LO are updated by mul/div.
- `div_zero` out 1: one-cycle pulse, coincident with `done`, for a divide by zero.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- **States:** IDLE, RUN, FIX. `busy` = (state != IDLE).
- **IDLE + start + mul/div op:**
  - Latch magnitudes |a| and |b|. Unsigned ops use raw values. Signed ops negate negative operands; the most-negative value's magnitude fits in WIDTH unsigned bits.
  - Latch the sign flags and the divide-by-zero flag (b == 0 on a divide op).
  - Clear the counter; go to RUN.
- **IDLE + start + MTHI/MTLO:** write `a` into `hi`/`lo` at that edge. State stays IDLE and `busy` stays 0. `done` is not pulsed.
- **IDLE + start + op 110/111:** ignored.
- **RUN:** one iteration per cycle for WIDTH cycles; counter width is $clog2(WIDTH)+1.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
  - After the last iteration go to FIX.
- **FIX (one cycle), mul/div result written at the exiting edge, back to IDLE, `done`=1 for the following cycle:**
  - **MULT:** negate the 2·WIDTH product if the operand signs differ. HI = upper half, LO = lower half.
  - **DIV:** quotient sign = sign(a) XOR sign(b); remainder takes the sign of `a`. LO = quotient, HI = remainder, both truncated to WIDTH. This gives most-negative / −1 → LO = most-negative, HI = 0.
  - **Divide by zero:** HI/LO unchanged; `div_zero` pulses with `done`.
- **start while busy:** ignored; no queueing.
- **cancel while busy:** takes effect at the next edge. State goes to IDLE, HI/LO are unchanged, and no `done` pulses. If `cancel` and `start` are both high in IDLE, `cancel` wins and the request is dropped.
- **Reset:** asynchronous, active-low, legal at any time including mid-operation.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, counter 0.
  - Internal datapath registers are also cleared.

## Timing
- Start sampled at edge k → `busy` high from edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles (33 for WIDTH=32).
- HI/LO are valid after edge k+WIDTH+1. `done` is high during the cycle after that edge, and `busy` is 0 in that same cycle.
- A new start is accepted in the `done` cycle, giving back-to-back throughput of WIDTH+2 cycles.
- MTHI/MTLO: result visible one edge after the start edge; zero busy cycles.
- `hi`/`lo` are registered outputs with no combinational path from inputs. `busy` and `done` decode from registers only.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_MTHI, OP_MTLO;
  - state encoding: S_IDLE, S_RUN, S_FIX.
- Single module; no sub-module is needed.
- Both ops share one 2·WIDTH shift register: the multiply accumulator / remainder:quotient pair.
- The control unit maps instruction decode to `op` and `start`. The PC enable is gated with `busy`.

## Test plan
All cases use WIDTH=32.
- **MULTU:** a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, one-cycle `done`.
- **MULT:** a=−3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **Divides:**
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** preload HI=0x11, LO=0x22 via MTHI/MTLO (no busy), then DIVU 5/0 → `done` and `div_zero` pulse together; HI/LO stay 0x11/0x22.
- **Abort and ignored start:**
  - Start MULTU, then at busy cycle 10 assert `start` with DIVU (ignored) and `cancel` → `busy` drops next edge, no `done`, HI/LO unchanged.
  - Also assert `reset` low mid-RUN → all outputs 0 immediately.
- **Back-to-back:** MULTU 3×5 then DIVU 100/7 issued in the `done` cycle → HI=0, LO=15, then HI=2, LO=14 after a further 33 busy cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the iterative HI/LO multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: one-bit-per-cycle multiply/divide with HI/LO registers, start/busy/done handshake.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic is_div_q, is_div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic dz_q, dz_d, done_q, done_d, dzp_q, dzp_d;
    logic is_muldiv, req_div, is_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quot, rmd;
    logic [WIDTH:0] mul_sum, div_top, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;

    assign is_muldiv = (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
    assign req_div   = (op == OP_DIVU) || (op == OP_DIV);
    assign is_sgn    = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = is_sgn && a[WIDTH-1];
    assign b_neg     = is_sgn && b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;
    // Multiply: accumulator is product-high:multiplier, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: accumulator is remainder:quotient, shifted left with a restoring trial subtract.
    assign div_top   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_top - {1'b0, opnd_q};
    assign div_step  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign prod      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quot      = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rmd       = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dzp_d    = 1'b0;
        if (cancel) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (start && is_muldiv) begin
                state_d  = S_RUN;
                cnt_d    = '0;
                opnd_d   = req_div ? mag_b : mag_a;
                acc_d    = {{WIDTH{1'b0}}, req_div ? mag_a : mag_b};
                is_div_d = req_div;
                neg_a_d  = a_neg;
                neg_b_d  = b_neg;
                dz_d     = req_div && (b == '0);
            end
            hi_d = (start && op == OP_MTHI) ? a : hi_q;
            lo_d = (start && op == OP_MTLO) ? a : lo_q;
        end else if (state_q == S_RUN) begin
            acc_d   = is_div_q ? div_step : mul_step;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_RUN;
        end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dzp_d   = dz_q;
            if (!dz_q) {hi_d, lo_d} = is_div_q ? {rmd, quot} : prod;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dzp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dzp_q    <= dzp_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dzp_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors against an arithmetic reference model, checked every cycle.
module tb_muldiv_hilo;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int          remaining = 0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .cancel(cancel),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        case (o)
            3'd0: return ux * uy;
            3'd1: return sx * sy;
            3'd2: return {32'(ux % uy), 32'(ux / uy)};
            3'd3: return {32'(sx % sy), 32'(sx / sy)};
            default: return 64'b0;
        endcase
    endfunction

    // Reference model: result computed arithmetically at acceptance, released after 33 edges.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0; remaining = 0;
        end else begin
            m_done = 0;
            m_dz = 0;
            if (m_busy) begin
                remaining--;
                if (cancel) m_busy = 0;
                else if (remaining == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_dz = p_dz;
                    if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
                end
            end else if (start && !cancel) begin
                if (op <= 3'd3) begin
                    p_dz = op[1] && (b == 0);
                    if (!p_dz) {p_hi, p_lo} = model_res(op, a, b);
                    m_busy = 1;
                    remaining = 33;
                end else if (op == 3'd4) m_hi = a;
                else if (op == 3'd5) m_lo = a;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
        chk("cyc_done", {31'b0, done}, {31'b0, m_done});
        chk("cyc_div_zero", {31'b0, div_zero}, {31'b0, m_dz});
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
    end

    task automatic go(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_wait(input string name);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk({name, "_busy_cycles"}, n, 33);
        chk({name, "_done"}, {31'b0, done}, 32'd1);
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_model_hi"}, m_hi, eh);
        chk({name, "_model_lo"}, m_lo, el);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        expect_hilo("reset", 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        go(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_wait("multu");
        expect_hilo("multu", 32'hFFFFFFFE, 32'h00000001);
        @(negedge clock);
        chk("multu_done_pulse", {31'b0, done}, 32'd0);

        go(3'd1, 32'hFFFFFFFD, 32'd7);
        run_wait("mult");
        expect_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

        go(3'd3, 32'hFFFFFFF9, 32'd2);
        run_wait("div_neg");
        expect_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

        go(3'd2, 32'd7, 32'd2);
        run_wait("divu");
        expect_hilo("divu", 32'd1, 32'd3);

        go(3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_wait("div_min");
        expect_hilo("div_min", 32'h0, 32'h80000000);

        go(3'd4, 32'h11, 32'h0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        go(3'd5, 32'h22, 32'h0);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);
        expect_hilo("mthilo", 32'h11, 32'h22);
        go(3'd2, 32'd5, 32'd0);
        run_wait("divz");
        chk("divz_flag", {31'b0, div_zero}, 32'd1);
        expect_hilo("divz", 32'h11, 32'h22);

        go(3'd7, 32'h5, 32'h0);
        chk("nop_busy", {31'b0, busy}, 32'd0);

        go(3'd0, 32'd9, 32'd9);
        repeat (9) @(negedge clock);
        op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1; cancel = 1'b1;
        @(negedge clock);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_busy", {31'b0, busy}, 32'd0);
        chk("cancel_done", {31'b0, done}, 32'd0);
        expect_hilo("cancel", 32'h11, 32'h22);
        repeat (3) @(negedge clock);

        go(3'd0, 32'd3, 32'd5);
        run_wait("b2b_mul");
        expect_hilo("b2b_mul", 32'd0, 32'd15);
        go(3'd2, 32'd100, 32'd7);
        run_wait("b2b_div");
        expect_hilo("b2b_div", 32'd2, 32'd14);

        go(3'd0, 32'd123, 32'd456);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("areset_busy", {31'b0, busy}, 32'd0);
        chk("areset_done", {31'b0, done}, 32'd0);
        chk("areset_div_zero", {31'b0, div_zero}, 32'd0);
        expect_hilo("areset", 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
